// File: rtl/down_counter_if.sv
// -----------------------------------------------------------------------------
// down_counter_if
//
// Purpose: groups the control inputs and status outputs of down_counter into a
// single bundle. The clock and the reset stay plain ports on the counter.
//
// Parameters:
//   WIDTH       counter width in bits (>= 2)
//
// Signals:
//   load        load request, sampled on the falling clock edge
//   load_value  value written to q on an accepted load
//   start       start-countdown request
//   stop        abort countdown, q is held
//   enable      count enable while running, low pauses the count
//   q           current count
//   busy        high while counting (RUN)
//   done        one-cycle pulse on reaching terminal count
//   zero        combinational q == 0
//
// Modports:
//   master      controller side: drives requests, observes status
//   slave       counter side: observes requests, drives status
// -----------------------------------------------------------------------------
interface down_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             enable;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load,
    output load_value,
    output start,
    output stop,
    output enable,
    input  q,
    input  busy,
    input  done,
    input  zero
  );

  modport slave (
    input  load,
    input  load_value,
    input  start,
    input  stop,
    input  enable,
    output q,
    output busy,
    output done,
    output zero
  );

endinterface : down_counter_if

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Purpose: loadable, start/stop-controlled down counter with terminal-count
// detection. A controller loads a count, starts it, and waits for the one-cycle
// done pulse. Intended as an interval timer or event down-counter.
//
// All state updates happen on the FALLING edge of clock. clear is an
// asynchronous, active-high reset.
//
// Parameters:
//   WIDTH       counter width in bits (>= 2), default 4
//
// Ports:
//   clock       clock, state updates on the falling edge
//   clear       asynchronous active-high reset
//   bus         down_counter_if.slave bundle:
//                 load / load_value / start / stop / enable  (inputs)
//                 q / busy / done / zero                     (outputs)
//
// Input priority at each falling edge: stop > load > start.
//
// Optional feature (compile-time macro DOWN_COUNTER_AUTO_RELOAD_EN):
//   When defined, a reload register captures load_value on every accepted
//   load, and DONE re-enters RUN with q = reload value (if non-zero), giving a
//   periodic done tick with period reload + 1 cycles. Only stop or clear
//   leaves the loop. When undefined, DONE always returns to IDLE with q = 0.
// -----------------------------------------------------------------------------
module down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clock,
  input  logic           clear,
  down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CountZero = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // ---------------------------------------------------------------------------
  // State and count registers (falling edge, async clear)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      count_q <= CountZero;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  // NOTE: the reload register is a single control register, not a storage
  // array, so it is reset like any other state; clear must also forget the
  // last reload value so a cleared counter cannot silently restart a loop.
  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      reload_q <= CountZero;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-count logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets its hold value first, so any path
  // through the case statement that does not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // stop has no effect in IDLE, but still masks load and start because
        // it has the highest priority.
        if (!bus.stop) begin
          if (bus.load) begin
            // A simultaneous start is dropped: the load wins.
            count_d = bus.load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = bus.load_value;
`endif
          end else if (bus.start) begin
            // Starting from zero skips RUN and pulses done right away.
            state_d = (count_q == CountZero) ? S_DONE : S_RUN;
          end
        end
      end

      S_RUN: begin
        // load and start are ignored while running.
        if (bus.stop) begin
          state_d = S_IDLE;             // abort, q held, no done pulse
        end else if (bus.enable) begin
          count_d = count_q - CountOne;
          // The count never decrements from zero: leaving RUN on the 1 -> 0
          // step is what rules out underflow.
          if (count_q == CountOne) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // q is already zero here; DONE lasts exactly one cycle.
        state_d = S_IDLE;
        count_d = CountZero;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        if (!bus.stop && (reload_q != CountZero)) begin
          state_d = S_RUN;
          count_d = reload_q;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        count_d = CountZero;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: status decoded straight from state, zero flag straight from q
  // ---------------------------------------------------------------------------
  assign bus.q    = count_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.zero = (count_q == CountZero);

endmodule : down_counter

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Drives a 4-bit and an 8-bit down_counter with identical stimulus. For every
// cycle the driver advances a behavioural model of each counter and queues the
// expected outputs; a monitor on the rising edge (state changes on the falling
// edge) pops the queues and compares. Asynchronous clear is checked directly.
// Honours DOWN_COUNTER_AUTO_RELOAD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_down_counter;

  logic clock = 1'b0;
  logic clear = 1'b0;

  always #5 clock = ~clock;

  down_counter_if #(.WIDTH(4)) bus4 ();
  down_counter_if #(.WIDTH(8)) bus8 ();

  down_counter #(.WIDTH(4)) dut4 (.clock(clock), .clear(clear), .bus(bus4.slave));
  down_counter #(.WIDTH(8)) dut8 (.clock(clock), .clear(clear), .bus(bus8.slave));

  typedef struct {
    int q;
    bit busy;
    bit done;
    bit zero;
  } obs_t;

  obs_t exp4_q[$];
  obs_t exp8_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 idle, 1 counting, 2 terminal-count cycle.
  // Index 0 models the 4-bit counter, index 1 the 8-bit one.
  // ---------------------------------------------------------------------------
  int m_phase [2];
  int m_count [2];
  int m_reload[2];
  int m_mod   [2] = '{16, 256};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i]  = 0;
      m_count[i]  = 0;
      m_reload[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit ld, input int lv,
                            input bit st, input bit sp, input bit en);
    case (m_phase[i])
      0: begin
        if (sp) begin
          // nothing happens
        end else if (ld) begin
          m_count[i]  = lv % m_mod[i];
          m_reload[i] = lv % m_mod[i];
        end else if (st) begin
          m_phase[i] = (m_count[i] == 0) ? 2 : 1;
        end
      end
      1: begin
        if (sp) begin
          m_phase[i] = 0;
        end else if (en) begin
          m_count[i] = m_count[i] - 1;
          if (m_count[i] == 0) m_phase[i] = 2;
        end
      end
      default: begin
        m_phase[i] = 0;
        m_count[i] = 0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        if (!sp && m_reload[i] != 0) begin
          m_phase[i] = 1;
          m_count[i] = m_reload[i];
        end
`endif
      end
    endcase
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.q    = m_count[i];
    o.busy = (m_phase[i] == 1);
    o.done = (m_phase[i] == 2);
    o.zero = (m_count[i] == 0);
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one call = one falling edge of stimulus
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit ld, input int lv, input bit st,
                       input bit sp, input bit en);
    @(posedge clock);
    #1;
    bus4.load = ld; bus4.load_value = 4'(lv); bus4.start = st;
    bus4.stop = sp; bus4.enable = en;
    bus8.load = ld; bus8.load_value = 8'(lv); bus8.start = st;
    bus8.stop = sp; bus8.enable = en;
    model_step(0, ld, lv, st, sp, en);
    model_step(1, ld, lv, st, sp, en);
    exp4_q.push_back(model_obs(0));
    exp8_q.push_back(model_obs(1));
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load_start(input int lv);
    cycle(1'b1, lv, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
  endtask

  // Leave any running or reloading loop and return to IDLE.
  task automatic settle();
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    nop(1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_q4"},    int'(bus4.q),    0);
    check({tag, "_busy4"}, int'(bus4.busy), 0);
    check({tag, "_done4"}, int'(bus4.done), 0);
    check({tag, "_zero4"}, int'(bus4.zero), 1);
    check({tag, "_q8"},    int'(bus8.q),    0);
    check({tag, "_busy8"}, int'(bus8.busy), 0);
    check({tag, "_done8"}, int'(bus8.done), 0);
  endtask

  // Assert clear between edges and verify it acts before any clock edge.
  task automatic do_clear();
    @(posedge clock);
    #1;
    bus4.load = 1'b0; bus4.start = 1'b0; bus4.stop = 1'b0;
    bus8.load = 1'b0; bus8.start = 1'b0; bus8.stop = 1'b0;
    #1;
    check("pre_clear_busy4", int'(bus4.busy), 1);
    check("pre_clear_q8", int'(bus8.q), 9);
    clear = 1'b1;
    #1;
    check_cleared("async_clear");
    #6;
    clear = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares the state produced by the previous falling edge
  // ---------------------------------------------------------------------------
  initial begin
    obs_t e;
    forever begin
      @(posedge clock);
      if (exp4_q.size() > 0) begin
        e = exp4_q.pop_front();
        check("q4",    int'(bus4.q),    e.q);
        check("busy4", int'(bus4.busy), int'(e.busy));
        check("done4", int'(bus4.done), int'(e.done));
        check("zero4", int'(bus4.zero), int'(e.zero));
      end
      if (exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        check("q8",    int'(bus8.q),    e.q);
        check("busy8", int'(bus8.busy), int'(e.busy));
        check("done8", int'(bus8.done), int'(e.done));
        check("zero8", int'(bus8.zero), int'(e.zero));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus4.load = 1'b0; bus4.load_value = '0; bus4.start = 1'b0;
    bus4.stop = 1'b0; bus4.enable = 1'b0;
    bus8.load = 1'b0; bus8.load_value = '0; bus8.start = 1'b0;
    bus8.stop = 1'b0; bus8.enable = 1'b0;
    model_reset();

    #1 clear = 1'b1;
    #1 check_cleared("reset");
    #11 clear = 1'b0;

    // Basic count: 5,4,3,2,1,0 then IDLE.
    load_start(5);
    nop(7);

    // Pause at 6 for three cycles, then abort at 4.
    settle();
    load_start(8);
    nop(2);
    for (int k = 0; k < 3; k++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    nop(2);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    nop(3);

    // load + start together: only the load happens.
    settle();
    cycle(1'b1, 3, 1'b1, 1'b0, 1'b1);
    nop(2);

    // start from zero: immediate done.
    cycle(1'b1, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    nop(2);

    // load during RUN is ignored.
    settle();
    load_start(4);
    cycle(1'b1, 11, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 12, 1'b1, 1'b0, 1'b1);
    nop(4);

    // Full-scale 4-bit load: no wrap.
    settle();
    load_start(15);
    nop(17);

    // 8-bit long count (4-bit instance sees 200 mod 16 = 8).
    settle();
    load_start(200);
    nop(202);

    // Asynchronous clear mid-RUN with q = 9, then normal reuse.
    settle();
    load_start(9);
    do_clear();
    load_start(2);
    nop(4);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Periodic tick: 3,2,1,0,3,... until stop; then load 0 gives one done.
    settle();
    load_start(3);
    nop(12);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    nop(3);
    load_start(0);
    nop(4);
`endif

    // Randomized traffic.
    settle();
    for (int k = 0; k < 1500; k++) begin
      bit ld, st, sp, en;
      int lv;
      ld = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 4) != 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      cycle(ld, lv, st, sp, en);
    end

    @(posedge clock);
    #1;
    check("sb_drained4", exp4_q.size(), 0);
    check("sb_drained8", exp8_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_down_counter
